// File: rtl/data_sram_responder_if.sv
// Data-SRAM style bus between a CPU data port and the responder.
// Requests are always accepted. Read data returns one cycle after the request.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Single-cycle data SRAM plus a small MMIO window (LED, SWITCH, TIMER, SCRATCH).
// Every request is accepted in its cycle. Read data is registered with a latency of 1.
module data_sram_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  data_sram_responder_if.slave         bus,
  output logic [15:0]                  led,
  input  logic [7:0]                   switch
);

  localparam int DEPTH = 1 << RAM_AW;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [15:0]       led_q, led_d;
  logic [7:0]        sw_meta_q, sw_sync_q;

  logic              mmio_hit, acc_wr, acc_rd, ram_we;
  logic [RAM_AW-1:0] word_idx;
  logic [13:0]       reg_off;
  logic [31:0]       reg_rdata, reg_wdata;
  logic              unused_addr_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign mmio_hit         = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign word_idx         = bus.data_sram_addr[RAM_AW+1:2];
  assign reg_off          = bus.data_sram_addr[15:2];
  assign acc_wr           = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
  assign acc_rd           = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
  assign ram_we           = acc_wr && !mmio_hit;
  assign unused_addr_bits = ^bus.data_sram_addr[1:0];

  // Register map; the timer is read as its value before the current edge.
  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      14'h0:   reg_rdata = {16'h0000, led_q};
      14'h1:   reg_rdata = {24'h0, sw_sync_q};
      14'h2:   reg_rdata = timer_q;
      14'h3:   reg_rdata = scratch_q;
      default: reg_rdata = '0;
    endcase
  end

  always_comb begin
    reg_wdata = byte_merge(reg_rdata, bus.data_sram_wdata, bus.data_sram_wen);
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    rdata_d   = rdata_q;
    if (acc_wr && mmio_hit) begin
      case (reg_off)
        14'h0:   led_d     = reg_wdata[15:0];
        14'h2:   timer_d   = reg_wdata;
        14'h3:   scratch_d = reg_wdata;
        default: ;
      endcase
    end
    if (acc_rd) rdata_d = mmio_hit ? reg_rdata : mem_q[word_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      scratch_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents survive reset; resetn only blocks writes while asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) mem_q[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder against a map-level reference model.
module tb_data_sram_responder;
  localparam int RAM_AW = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] led;
  logic [7:0]  switch;

  data_sram_responder_if bus ();

  data_sram_responder #(.RAM_AW(RAM_AW), .MMIO_BASE(32'hbfaf_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .led    (led),
    .switch (switch)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_exp = '0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [15:0] led_m     = '0;
  logic [31:0] timer_m   = '0;
  logic [31:0] scratch_m = '0;
  logic [7:0]  sw_s1 = '0, sw_s2 = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_mmio(logic [31:0] a);
    return a[31:16] == 16'hbfaf;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << RAM_AW) - 32'd1));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (is_mmio(a)) begin
      if (a[15:0] >= 16'h0000 && a[15:0] <= 16'h0003) return {16'h0, led_m};
      if (a[15:0] >= 16'h0004 && a[15:0] <= 16'h0007) return {24'h0, sw_s2};
      if (a[15:0] >= 16'h0008 && a[15:0] <= 16'h000b) return timer_m;
      if (a[15:0] >= 16'h000c && a[15:0] <= 16'h000f) return scratch_m;
      return 32'h0;
    end
    if (ram_m.exists(widx(a))) return ram_m[widx(a)];
    return 'x;
  endfunction

  // Drives one request, lets one rising edge pass, updates the model, returns at the falling edge.
  task automatic cycle(input bit en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] tmp;
    bit          timer_wr;
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    if (en && wen == 4'b0 && resetn) begin
      exp_q.push_back(model_read(addr));
      last_exp = model_read(addr);
    end
    @(posedge clk);
    if (!resetn) begin
      led_m = '0; timer_m = '0; scratch_m = '0; sw_s1 = '0; sw_s2 = '0; last_exp = '0;
    end else begin
      timer_wr = en && wen != 4'b0 && is_mmio(addr) && addr[15:2] == 14'd2;
      if (en && wen != 4'b0) begin
        if (is_mmio(addr)) begin
          if (addr[15:2] == 14'd0) begin
            tmp = merge({16'h0, led_m}, wdata, wen);
            led_m = tmp[15:0];
          end else if (addr[15:2] == 14'd3) begin
            scratch_m = merge(scratch_m, wdata, wen);
          end
        end else begin
          tmp = ram_m.exists(widx(addr)) ? ram_m[widx(addr)] : 32'hx;
          ram_m[widx(addr)] = merge(tmp, wdata, wen);
        end
      end
      timer_m = timer_wr ? merge(timer_m, wdata, wen) : timer_m + 32'd1;
      sw_s2 = sw_s1;
      sw_s1 = switch;
    end
    @(negedge clk);
    if (resetn && !(en && wen == 4'b0)) check("rd_hold", bus.data_sram_rdata, last_exp);
  endtask

  // Scoreboard monitor: every accepted read is compared one cycle later.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (resetn === 1'b1 && bus.data_sram_en === 1'b1 && bus.data_sram_wen === 4'b0) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %h expected no read", bus.data_sram_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", bus.data_sram_rdata, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, d;
    logic [3:0]  w;
    int          r;
    resetn = 1'b0;
    switch = 8'h00;
    bus.data_sram_en = 1'b0; bus.data_sram_wen = '0; bus.data_sram_addr = '0; bus.data_sram_wdata = '0;
    #1;
    check("reset_rdata", bus.data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Full write, read back, byte-lane write, idle hold
    cycle(1, 4'hf, 32'h0000_1000, 32'hdead_beef);
    cycle(1, 4'h0, 32'h0000_1000, 32'h0);
    cycle(1, 4'b0010, 32'h0000_1000, 32'h0000_5500);
    cycle(1, 4'h0, 32'h0000_1000, 32'h0);
    cycle(0, 4'h0, 32'h0, 32'h0);
    check("byte_write_const", bus.data_sram_rdata, 32'hdead_55ef);

    // LED
    cycle(1, 4'hf, 32'hbfaf_0000, 32'h1234_a5a5);
    check("led_out", {16'h0, led}, 32'h0000_a5a5);
    cycle(1, 4'h0, 32'hbfaf_0000, 32'h0);

    // TIMER write then wrap
    cycle(1, 4'hf, 32'hbfaf_0008, 32'hffff_fffe);
    cycle(1, 4'h0, 32'hbfaf_0008, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0008, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0008, 32'h0);
    check("timer_wrap_const", bus.data_sram_rdata, 32'h0);

    // SWITCH via synchronizer, unmapped offset, ignored writes
    switch = 8'h3c;
    repeat (3) cycle(0, 4'h0, 32'h0, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0004, 32'h0);
    check("switch_const", bus.data_sram_rdata, 32'h0000_003c);
    cycle(1, 4'hf, 32'hbfaf_0004, 32'hffff_ffff);
    cycle(1, 4'hf, 32'hbfaf_0010, 32'hffff_ffff);
    cycle(1, 4'h0, 32'hbfaf_0010, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0004, 32'h0);

    // SCRATCH byte enables
    cycle(1, 4'hf, 32'hbfaf_000c, 32'h0102_0304);
    cycle(1, 4'b1001, 32'hbfaf_000c, 32'haabb_ccdd);
    cycle(1, 4'h0, 32'hbfaf_000c, 32'h0);

    // Random traffic over a small aliased RAM region and the register window
    for (int i = 0; i < 16; i++) cycle(1, 4'hf, 32'(i) << 2, $urandom);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) switch = 8'($urandom);
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (r <= 5) a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      else        a = 32'hbfaf_0000 | (32'($urandom_range(0, 4)) << 2) | 32'($urandom_range(0, 3));
      cycle(r != 9, w, a, d);
    end

    // Reset with a read just completed, requests ignored during reset
    cycle(1, 4'hf, 32'hbfaf_0000, 32'h0000_5a5a);
    cycle(1, 4'h0, 32'hbfaf_0000, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_rdata", bus.data_sram_rdata, 32'h0);
    check("async_rst_led", {16'h0, led}, 32'h0);
    cycle(1, 4'hf, 32'hbfaf_0000, 32'hffff_ffff);
    cycle(1, 4'h0, 32'h0000_0000, 32'h0);
    check("rst_rdata_held", bus.data_sram_rdata, 32'h0);
    check("rst_led_held", {16'h0, led}, 32'h0);
    resetn = 1'b1;
    cycle(1, 4'h0, 32'hbfaf_0008, 32'h0);
    check("timer_after_rst", bus.data_sram_rdata, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0000, 32'h0);
    cycle(1, 4'h0, 32'hbfaf_0008, 32'h0);
    cycle(0, 4'h0, 32'h0, 32'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
